// File: rtl/i2c_arb_pkg.sv
// Shared FSM encoding and default widths for the I2C master arbiter.
package i2c_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr_i, wrapping.
module i2c_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   winner_o
);
  int idx;

  // Scan from farthest to nearest so the nearest set bit is the last write.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_i) + k) % NUM_REQ;
      if (req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ write requesters.
// Optional WAIT-state timeout enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = i2c_arb_pkg::ADDR_W,
  parameter int DATA_W      = i2c_arb_pkg::DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [NUM_REQ-1:0]          nack,
  output logic                        m_start,
  output logic [ADDR_W-1:0]           m_slave_addr,
  output logic [DATA_W-1:0]           m_data,
  input  logic                        m_done,
  input  logic                        m_ack,
  output logic                        busy,
  output logic                        timeout
);
  import i2c_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("i2c_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 2");
  end

  state_e              state_q;
  logic [IDX_W-1:0]    rr_ptr_q, win_q, pick_idx;
  logic                pick_vld;
  logic [NUM_REQ-1:0]  gnt_q, done_q, nack_q;
  logic                m_start_q, busy_q, timeout_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [IDX_W-1:0]    rr_ptr_d;
  logic                expire;

  i2c_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_vld),
    .winner_o (pick_idx)
  );

  assign rr_ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q;
  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      nack_q    <= '0;
      m_start_q <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      m_start_q <= 1'b0;
      done_q    <= '0;
      nack_q    <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (pick_vld) begin
          win_q     <= pick_idx;
          gnt_q     <= NUM_REQ'(1) << pick_idx;
          addr_q    <= req_addr[pick_idx*ADDR_W +: ADDR_W];
          data_q    <= req_data[pick_idx*DATA_W +: DATA_W];
          m_start_q <= 1'b1;
          busy_q    <= 1'b1;
          state_q   <= ISSUE;
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        // Response is registered on the WAIT exit edge so done/nack show in RESP.
        WAIT: begin
          if (m_done) begin
            done_q  <= gnt_q;
            nack_q  <= m_ack ? '0 : gnt_q;
            state_q <= RESP;
          end else if (expire) begin
            done_q    <= gnt_q;
            nack_q    <= gnt_q;
            timeout_q <= 1'b1;
            state_q   <= RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else cnt_q <= cnt_q + 1'b1;
`endif
        end
        RESP: begin
          gnt_q    <= '0;
          busy_q   <= 1'b0;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign nack         = nack_q;
  assign m_start      = m_start_q;
  assign m_slave_addr = addr_q;
  assign m_data       = data_q;
  assign busy         = busy_q;
  assign timeout      = timeout_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: stimulus queues expected starts/responses, monitor pops them.
module tb_i2c_master_arbiter;
  localparam int N = 4, AW = 8, DW = 8, TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt, done, nack;
  logic            m_start, m_done, m_ack, busy, timeout;
  logic [AW-1:0]   m_slave_addr;
  logic [DW-1:0]   m_data;
  logic            mdl_done, mdl_ack, spur_done;

  assign m_done = mdl_done | spur_done;
  assign m_ack  = mdl_ack;

  always #5 clk = ~clk;

  i2c_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .nack(nack), .m_start(m_start),
    .m_slave_addr(m_slave_addr), .m_data(m_data), .m_done(m_done), .m_ack(m_ack),
    .busy(busy), .timeout(timeout)
  );

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } start_t;

  typedef struct packed {
    logic [N-1:0]  done;
    logic [N-1:0]  nack;
    logic          to;
    logic [AW-1:0] addr;
  } resp_t;

  start_t exp_start[$];
  resp_t  exp_resp[$];
  start_t s_e;
  resp_t  r_e;

  int vectors = 0, miscompares = 0;
  int cyc = 0, n_start = 0, n_done = 0, cyc_start = 0, cyc_done = 0;
  int base, nst;
  logic master_en = 1'b1, ack_cfg = 1'b1;
  int   lat_cfg = 3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic wait_done(input int target, input string name);
    int t = 0;
    while (n_done < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(n_done >= target), 1);
  endtask

  task automatic wait_gnt(input string name, input logic [N-1:0] exp);
    int t = 0;
    while (gnt == '0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check(name, gnt, exp);
  endtask

  // Master model: answers each m_start after lat_cfg cycles.
  initial begin
    mdl_done = 1'b0;
    mdl_ack  = 1'b0;
    forever begin
      @(negedge clk);
      if (m_start && master_en) begin
        repeat (lat_cfg) @(negedge clk);
        mdl_done = 1'b1;
        mdl_ack  = ack_cfg;
        @(negedge clk);
        mdl_done = 1'b0;
        mdl_ack  = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT starts or completes.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (m_start) begin
          n_start++;
          cyc_start = cyc;
          if (exp_start.size() == 0) check("unexpected_m_start", 1, 0);
          else begin
            s_e = exp_start.pop_front();
            check("start_gnt_addr_data", {gnt, m_slave_addr, m_data}, s_e);
          end
        end
        if (done != '0 || timeout) begin
          n_done++;
          cyc_done = cyc;
          if (exp_resp.size() == 0) check("spurious_done", {done, nack, timeout}, 0);
          else begin
            r_e = exp_resp.pop_front();
            check("resp_done_nack_to_addr", {done, nack, timeout, m_slave_addr}, r_e);
          end
        end
        if ($countones(gnt) > 1 || $countones(done) > 1 || $countones(nack) > 1)
          check("onehot", {gnt, done, nack}, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = '0; req_addr = '0; req_data = '0; spur_done = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", {gnt, done, nack, m_start, timeout, busy, m_slave_addr, m_data}, 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);

    // Single request, requester 1
    set_slot(1, 8'h50, 8'hA5);
    exp_start.push_back(start_t'{4'b0010, 8'h50, 8'hA5});
    exp_resp.push_back(resp_t'{4'b0010, 4'b0000, 1'b0, 8'h50});
    base = n_done;
    req = 4'b0010;
    @(negedge clk);
    check("gnt_start_latency", {gnt, m_start}, {4'b0010, 1'b1});
    req = '0;
    wait_done(base + 1, "single_done");
    check("done_latency", cyc_done - cyc_start, lat_cfg + 1);
    repeat (2) @(negedge clk);
    check("busy_after_resp", busy, 0);

    // Contention after reset: grant order 0,1,2,3,0
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_slot(i, 8'h10 + 8'(i), 8'hC0 + 8'(i));
    for (int k = 0; k < 5; k++) begin
      exp_start.push_back(start_t'{4'(1 << (k % N)), 8'h10 + 8'(k % N), 8'hC0 + 8'(k % N)});
      exp_resp.push_back(resp_t'{4'(1 << (k % N)), 4'b0000, 1'b0, 8'h10 + 8'(k % N)});
    end
    base = n_done;
    nst  = n_start;
    req  = 4'b1111;
    for (int t = 0; t < 400 && n_start < nst + 5; t++) @(negedge clk);
    req = '0;
    check("contention_starts", 64'(n_start >= nst + 5), 1);
    wait_done(base + 5, "contention_done");

    // NACK from slave, requester 2
    ack_cfg = 1'b0;
    set_slot(2, 8'h3C, 8'h5A);
    exp_start.push_back(start_t'{4'b0100, 8'h3C, 8'h5A});
    exp_resp.push_back(resp_t'{4'b0100, 4'b0100, 1'b0, 8'h3C});
    base = n_done;
    req = 4'b0100;
    @(negedge clk);
    wait_gnt("nack_gnt", 4'b0100);
    req = '0;
    wait_done(base + 1, "nack_done");
    ack_cfg = 1'b1;

    // Input isolation and m_done while idle
    lat_cfg = 8;
    set_slot(0, 8'h50, 8'h77);
    exp_start.push_back(start_t'{4'b0001, 8'h50, 8'h77});
    exp_resp.push_back(resp_t'{4'b0001, 4'b0000, 1'b0, 8'h50});
    base = n_done;
    req = 4'b0001;
    @(negedge clk);
    wait_gnt("iso_gnt", 4'b0001);
    req = '0;
    repeat (3) @(negedge clk);
    set_slot(0, 8'h22, 8'h11);
    @(negedge clk);
    check("addr_isolated", {m_slave_addr, m_data}, {8'h50, 8'h77});
    wait_done(base + 1, "iso_done");
    repeat (3) @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk) spur_done = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_m_done_ignored", n_done, base + 1);

    // Reset in the middle of WAIT
    lat_cfg = 20;
    set_slot(3, 8'h61, 8'h62);
    exp_start.push_back(start_t'{4'b1000, 8'h61, 8'h62});
    req = 4'b1000;
    @(negedge clk);
    wait_gnt("midrst_gnt", 4'b1000);
    req = '0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", {gnt, done, nack, m_start, timeout, busy, m_slave_addr, m_data}, 0);
    @(negedge clk) reset = 1'b0;
    nst  = n_start;
    base = n_done;
    repeat (30) @(negedge clk);
    check("no_restart_after_reset", n_start, nst);
    check("no_done_after_reset", n_done, base);

`ifdef I2C_ARB_TIMEOUT_EN
    // Master never answers: 16 WAIT cycles then timeout/done/nack together
    master_en = 1'b0;
    set_slot(1, 8'h44, 8'h99);
    exp_start.push_back(start_t'{4'b0010, 8'h44, 8'h99});
    exp_resp.push_back(resp_t'{4'b0010, 4'b0010, 1'b1, 8'h44});
    base = n_done;
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    wait_done(base + 1, "timeout_done");
    check("timeout_wait_cycles", cyc_done - cyc_start, TO + 1);
    master_en = 1'b1;
    lat_cfg = 3;
    set_slot(2, 8'h66, 8'h77);
    exp_start.push_back(start_t'{4'b0100, 8'h66, 8'h77});
    exp_resp.push_back(resp_t'{4'b0100, 4'b0000, 1'b0, 8'h66});
    base = n_done;
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    wait_done(base + 1, "after_timeout_done");
`else
    // Slow master well beyond TIMEOUT_CYC: completes normally, no timeout
    lat_cfg = 40;
    set_slot(1, 8'h44, 8'h99);
    exp_start.push_back(start_t'{4'b0010, 8'h44, 8'h99});
    exp_resp.push_back(resp_t'{4'b0010, 4'b0000, 1'b0, 8'h44});
    base = n_done;
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    wait_done(base + 1, "slow_master_done");
    check("slow_master_latency", cyc_done - cyc_start, 41);
`endif

    repeat (5) @(negedge clk);
    check("queues_drained", exp_start.size() + exp_resp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
